// File: rtl/onehot_stream_encoder.sv
// onehot_stream_encoder
// Accepts an N-bit vector over a valid/ready handshake and replays the
// binary index of every set bit, lowest index first, one code per output
// handshake. out_last marks the final code of each vector. Outputs depend
// only on registered state, so there is no input-to-output combinational path.
module onehot_stream_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;

  // Priority encoder: bit 0 has the highest priority, so scan downward and
  // let the lowest set bit overwrite. An all-zero vector yields index 0.
  function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit of v is set (zero is not single).
  function automatic logic is_single(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  // In IDLE pending is always zero, so these reduce to the required
  // qualified-zero outputs without extra gating.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_code  = lowest_index(pending_q);
  assign out_last  = is_single(pending_q);

  // Next-state logic: load a vector in IDLE, retire the lowest set bit per
  // output handshake in EMIT.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        pending_d = in_vec;
        state_d   = (in_vec != '0) ? EMIT : IDLE;
      end
    end else begin
      if (out_ready) begin
        // v & (v-1) clears exactly the lowest set bit, i.e. the one being emitted.
        pending_d = pending_q & (pending_q - N'(1));
        if (out_last) state_d = IDLE;
      end
    end
  end

  // State and pending registers; reset abandons any in-flight vector at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Directed bench for onehot_stream_encoder (N=8, W=3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_onehot_stream_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;

  int total;
  int bad;
  logic [7:0] acc;

  onehot_stream_encoder #(.N(8), .W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [2:0] c,
                         input logic l, input logic r);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".code"},  32'(out_code),  32'(c));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".ready"}, 32'(in_ready),  32'(r));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [7:0] dec3to8(input logic [2:0] c);
    return 8'b1 << c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      step();
      exp_out("rst", 1'b0, 3'd0, 1'b0, 1'b1);
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
    end
    step();
    in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
    rst_n = 1'b1;
    step();
    exp_out("idle", 1'b0, 3'd0, 1'b0, 1'b1);

    // 8'b0010_0101 -> 0, 2, 5
    in_valid = 1'b1; in_vec = 8'b0010_0101; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_vec = 8'h00;
    exp_out("v25.c0", 1'b1, 3'd0, 1'b0, 1'b0);
    step();
    exp_out("v25.c2", 1'b1, 3'd2, 1'b0, 1'b0);
    step();
    exp_out("v25.c5", 1'b1, 3'd5, 1'b1, 1'b0);
    step();
    exp_out("v25.end", 1'b0, 3'd0, 1'b0, 1'b1);

    // Backpressure with 8'b1000_0001
    in_valid = 1'b1; in_vec = 8'b1000_0001; out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_vec = 8'h00;
    for (int i = 0; i < 3; i++) begin
      exp_out($sformatf("bp.hold%0d", i), 1'b1, 3'd0, 1'b0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    exp_out("bp.c0", 1'b1, 3'd0, 1'b0, 1'b0);
    step();
    exp_out("bp.c7", 1'b1, 3'd7, 1'b1, 1'b0);
    step();
    exp_out("bp.end", 1'b0, 3'd0, 1'b0, 1'b1);

    // Zero vector is swallowed, then 8'h10 -> single code 4
    in_valid = 1'b1; in_vec = 8'h00;
    step();
    exp_out("zero.after", 1'b0, 3'd0, 1'b0, 1'b1);
    in_vec = 8'h10;
    step();
    in_valid = 1'b0; in_vec = 8'h00;
    exp_out("h10.c4", 1'b1, 3'd4, 1'b1, 1'b0);
    step();
    exp_out("h10.end", 1'b0, 3'd0, 1'b0, 1'b1);

    // Full vector with in_valid held high; decode-and-OR round trip
    acc = 8'h00;
    in_valid = 1'b1; in_vec = 8'hFF;
    step();
    for (int i = 0; i < 8; i++) begin
      exp_out($sformatf("ff.c%0d", i), 1'b1, 3'(i), (i == 7), 1'b0);
      if (out_valid) acc = acc | dec3to8(out_code);
      step();
    end
    chk("ff.ready_back", 32'(in_ready), 32'd1);
    chk("ff.valid_back", 32'(out_valid), 32'd0);
    in_valid = 1'b0; in_vec = 8'h00;
    chk("ff.roundtrip", 32'(acc), 32'hFF);
    step();
    exp_out("ff.idle", 1'b0, 3'd0, 1'b0, 1'b1);

    // Reset mid-stream after code 1 handshakes
    in_valid = 1'b1; in_vec = 8'hFF;
    step();
    in_valid = 1'b0; in_vec = 8'h00;
    exp_out("mid.c0", 1'b1, 3'd0, 1'b0, 1'b0);
    step();
    exp_out("mid.c1", 1'b1, 3'd1, 1'b0, 1'b0);
    step();
    exp_out("mid.c2", 1'b1, 3'd2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_out("mid.async", 1'b0, 3'd0, 1'b0, 1'b1);
    step();
    exp_out("mid.held", 1'b0, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_out($sformatf("mid.quiet%0d", i), 1'b0, 3'd0, 1'b0, 1'b1);
    end
    in_valid = 1'b1; in_vec = 8'h40;
    step();
    in_valid = 1'b0; in_vec = 8'h00;
    exp_out("mid.new6", 1'b1, 3'd6, 1'b1, 1'b0);
    step();
    exp_out("mid.end", 1'b0, 3'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
